pcie_rx_descrambler: RTL and testbench
======================================

PCIE_RX_DESCRAMBLER -- requirements
Module: pcie_rx_descrambler

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 16: consecutive RxValid-low cycles that drop lock.
REQ-002 Parameter MAX_SKP, default 5: maximum SKP symbols allowed in one SKP ordered set.
REQ-003 ClkPci  input  1  single clock; all state on rising edge.
REQ-004 notResetPci  input  1  reset, asynchronous assert, active-low.
REQ-005 RxValid  input  1  RxData/RxDataK carry a symbol this cycle.
REQ-006 RxData  input  8  received 8b symbol, still scrambled.
REQ-007 RxDataK  input  1  symbol is a K-code.
REQ-008 DisableScramble  input  1  bypass XOR; LFSR still tracks.
REQ-009 DescValid  output  1  registered copy of accepted RxValid.
REQ-010 DescData  output  8  descrambled symbol.
REQ-011 DescDataK  output  1  registered RxDataK.
REQ-012 Locked  output  1  descrambler synchronised to a COM.
REQ-013 SkpErr  output  1  one-cycle pulse: SKP count exceeded MAX_SKP.

Function
REQ-014 LFSR: 16 bits, G(X)=X^16+X^5+X^4+X^3+1, seed 16'hFFFF, advanced 8 serial steps per symbol.
REQ-015 Per-symbol XOR byte = bit-reversed LFSR[15:8] (LFSR[15] to bit 0) of the LFSR value before the advance for that symbol.
REQ-016 COM (K, 8'hBC): LFSR loaded with seed, no advance; symbol passed unmodified.
REQ-017 SKP (K, 8'h1C): LFSR held; symbol passed unmodified.
REQ-018 Other K symbols: passed unmodified; LFSR advanced.
REQ-019 D symbols: DescData = RxData XOR XOR-byte when Locked=1 and DisableScramble=0, else RxData; LFSR advanced.
REQ-020 RxValid=0: LFSR and symbol handling frozen; DescValid=0 next cycle.
REQ-021 Latency: exactly 1 cycle, RxValid/RxData/RxDataK to DescValid/DescData/DescDataK.
REQ-022 States: UNLOCKED, LOCKED.
REQ-023 UNLOCKED -> LOCKED on valid COM; Locked rises with that COM's DescValid.
REQ-024 LOCKED -> UNLOCKED when the idle counter reaches LOCK_TIMEOUT; counter increments on RxValid=0, clears on RxValid=1, saturates at LOCK_TIMEOUT.
REQ-025 Any COM while LOCKED re-seeds the LFSR; state stays LOCKED.
REQ-026 SKP counter: cleared on COM, incremented per SKP, cleared on any non-SKP valid symbol; saturates at MAX_SKP+1.
REQ-027 SkpErr pulses once, aligned with the DescValid of the SKP that takes the count from MAX_SKP to MAX_SKP+1; no further pulse until cleared.
REQ-028 SKP with no preceding COM since lock: passed, LFSR held, counted.
REQ-029 DisableScramble changes take effect on the next accepted symbol; no glitch on the current output.

Reset
REQ-030 While notResetPci=0: LFSR=16'hFFFF, state UNLOCKED, counters 0, DescValid=0, DescData=8'h00, DescDataK=0, Locked=0, SkpErr=0.
REQ-031 Reset mid-stream discards the in-flight symbol; the first symbol after release is processed as UNLOCKED.

Structure
REQ-032 Shared package holds K_COM=8'hBC, K_SKP=8'h1C, LFSR_SEED=16'hFFFF, polynomial tap constants, state encoding.
REQ-033 One combinational sub-module pcie_lfsr_adv8 (16-bit in, advanced 16-bit out, XOR byte out), shared with the transmit scrambler.

Verification
REQ-034 Reset, COM then D 8'h00 x4 -> DescData FF,17,C0,14; Locked=1 from the COM.
REQ-035 COM, D 00, SKP, SKP, D 00 -> FF, 1C(K), 1C(K), 17; SKP holds the LFSR.
REQ-036 COM, six SKP -> SkpErr single pulse on the 6th SKP output; data unchanged.
REQ-037 Locked, RxValid low 16 cycles -> Locked=0; following D 8'h5A -> 5A unmodified.
REQ-038 DisableScramble=1, COM, D 00, D 00 -> 00, 00; then DisableScramble=0, D 00 -> C0.
REQ-039 notResetPci asserted mid-packet -> all outputs 0 asynchronously; post-release D passes raw until COM.

Source files
------------

// File: rtl/pcie_rx_descrambler_pkg.sv
// Shared constants, state encoding and LFSR helpers for the PCIe receive descrambler
// and the transmit scrambler.
package pcie_rx_descrambler_pkg;

    localparam logic [7:0]  K_COM     = 8'hBC;
    localparam logic [7:0]  K_SKP     = 8'h1C;
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    // G(X) = X^16 + X^5 + X^4 + X^3 + 1: the bit shifted out of 15 feeds bits 0, 3, 4 and 5
    localparam logic [15:0] LFSR_TAPS = 16'h0039;

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } rx_state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {cur[14:0], 1'b0};
        if (cur[15]) begin
            nxt = nxt ^ LFSR_TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pcie_rx_descrambler_if.sv
// Symbol stream into the descrambler and descrambled stream plus status out of it.
interface pcie_rx_descrambler_if;

    logic       RxValid;
    logic [7:0] RxData;
    logic       RxDataK;
    logic       DisableScramble;
    logic       DescValid;
    logic [7:0] DescData;
    logic       DescDataK;
    logic       Locked;
    logic       SkpErr;

    modport master (
        output RxValid, RxData, RxDataK, DisableScramble,
        input  DescValid, DescData, DescDataK, Locked, SkpErr
    );

    modport slave (
        input  RxValid, RxData, RxDataK, DisableScramble,
        output DescValid, DescData, DescDataK, Locked, SkpErr
    );

endinterface

// File: rtl/pcie_lfsr_adv8.sv
// One symbol's worth of scrambler LFSR: eight serial steps and the XOR byte taken
// from the pre-advance state. Purely combinational so the transmit side can share it.
module pcie_lfsr_adv8
    import pcie_rx_descrambler_pkg::*;
(
    input  logic [15:0] lfsr_cur_s,
    output logic [15:0] lfsr_adv_s,
    output logic [7:0]  xor_byte_s
);

    logic [15:0] lfsr_work_s;

    // Unrolled eight-step advance of the LFSR
    always_comb begin
        lfsr_work_s = lfsr_cur_s;
        for (int i = 0; i < 8; i++) begin
            lfsr_work_s = lfsr_step(lfsr_work_s);
        end
    end

    assign lfsr_adv_s = lfsr_work_s;
    assign xor_byte_s = bit_rev8(lfsr_cur_s[15:8]);

endmodule

// File: rtl/pcie_rx_descrambler.sv
// PCIe receive descrambler: resynchronises the LFSR on every COM and removes the
// transmitter's scrambling from data symbols with exactly one cycle of latency.
module pcie_rx_descrambler
    import pcie_rx_descrambler_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 16,
    parameter int MAX_SKP      = 5
) (
    input  logic                 ClkPci,
    input  logic                 notResetPci,
    pcie_rx_descrambler_if.slave bus
);

    localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int SKP_W  = $clog2(MAX_SKP + 2);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(LOCK_TIMEOUT);
    localparam logic [SKP_W-1:0]  SKP_LIM  = SKP_W'(MAX_SKP);
    localparam logic [SKP_W-1:0]  SKP_SAT  = SKP_W'(MAX_SKP + 1);

    rx_state_e         state_r;
    rx_state_e         state_next_s;
    logic [15:0]       lfsr_r;
    logic [15:0]       lfsr_next_s;
    logic [15:0]       lfsr_adv_s;
    logic [7:0]        xor_byte_s;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic [IDLE_W-1:0] idle_cnt_next_s;
    logic [SKP_W-1:0]  skp_cnt_r;
    logic [SKP_W-1:0]  skp_cnt_next_s;
    logic              skp_err_next_s;
    logic [7:0]        desc_data_next_s;
    logic              desc_k_next_s;
    logic              is_com_s;
    logic              is_skp_s;
    logic              desc_valid_r;
    logic [7:0]        desc_data_r;
    logic              desc_k_r;
    logic              locked_r;
    logic              skp_err_r;

    pcie_lfsr_adv8 u_lfsr_adv8 (
        .lfsr_cur_s (lfsr_r),
        .lfsr_adv_s (lfsr_adv_s),
        .xor_byte_s (xor_byte_s)
    );

    assign is_com_s = bus.RxDataK && (bus.RxData == K_COM);
    assign is_skp_s = bus.RxDataK && (bus.RxData == K_SKP);

    // Idle-gap counter: cleared by any accepted symbol, saturating at the timeout
    always_comb begin
        idle_cnt_next_s = idle_cnt_r;
        if (bus.RxValid) begin
            idle_cnt_next_s = {IDLE_W{1'b0}};
        end else if (idle_cnt_r != IDLE_MAX) begin
            idle_cnt_next_s = idle_cnt_r + IDLE_W'(1);
        end else begin
            idle_cnt_next_s = idle_cnt_r;
        end
    end

    // Lock FSM next state: COM acquires lock, a long enough RxValid gap drops it
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_UNLOCKED: begin
                if (bus.RxValid && is_com_s) begin
                    state_next_s = ST_LOCKED;
                end else begin
                    state_next_s = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (idle_cnt_next_s == IDLE_MAX) begin
                    state_next_s = ST_UNLOCKED;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: begin
                state_next_s = ST_UNLOCKED;
            end
        endcase
    end

    // Symbol handling: LFSR update, SKP run length and the descrambled byte
    always_comb begin
        lfsr_next_s      = lfsr_r;
        skp_cnt_next_s   = skp_cnt_r;
        skp_err_next_s   = 1'b0;
        desc_data_next_s = desc_data_r;
        desc_k_next_s    = desc_k_r;
        if (bus.RxValid) begin
            desc_data_next_s = bus.RxData;
            desc_k_next_s    = bus.RxDataK;
            if (is_com_s) begin
                lfsr_next_s    = LFSR_SEED;
                skp_cnt_next_s = {SKP_W{1'b0}};
            end else if (is_skp_s) begin
                lfsr_next_s = lfsr_r;
                // Error fires only on the transition into saturation, so once per run
                if (skp_cnt_r == SKP_LIM) begin
                    skp_err_next_s = 1'b1;
                end else begin
                    skp_err_next_s = 1'b0;
                end
                if (skp_cnt_r != SKP_SAT) begin
                    skp_cnt_next_s = skp_cnt_r + SKP_W'(1);
                end else begin
                    skp_cnt_next_s = skp_cnt_r;
                end
            end else begin
                lfsr_next_s    = lfsr_adv_s;
                skp_cnt_next_s = {SKP_W{1'b0}};
                if (!bus.RxDataK && (state_r == ST_LOCKED) && !bus.DisableScramble) begin
                    desc_data_next_s = bus.RxData ^ xor_byte_s;
                end else begin
                    desc_data_next_s = bus.RxData;
                end
            end
        end else begin
            lfsr_next_s = lfsr_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge ClkPci or negedge notResetPci) begin
        if (!notResetPci) begin
            state_r      <= ST_UNLOCKED;
            lfsr_r       <= LFSR_SEED;
            idle_cnt_r   <= {IDLE_W{1'b0}};
            skp_cnt_r    <= {SKP_W{1'b0}};
            desc_valid_r <= 1'b0;
            desc_data_r  <= 8'h00;
            desc_k_r     <= 1'b0;
            locked_r     <= 1'b0;
            skp_err_r    <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            lfsr_r       <= lfsr_next_s;
            idle_cnt_r   <= idle_cnt_next_s;
            skp_cnt_r    <= skp_cnt_next_s;
            desc_valid_r <= bus.RxValid;
            desc_data_r  <= desc_data_next_s;
            desc_k_r     <= desc_k_next_s;
            locked_r     <= (state_next_s == ST_LOCKED);
            skp_err_r    <= skp_err_next_s;
        end
    end

    assign bus.DescValid = desc_valid_r;
    assign bus.DescData  = desc_data_r;
    assign bus.DescDataK = desc_k_r;
    assign bus.Locked    = locked_r;
    assign bus.SkpErr    = skp_err_r;

endmodule

// File: tb/tb_pcie_rx_descrambler.sv
// Bench for pcie_rx_descrambler: directed scenarios plus a randomized symbol stream
// checked against a symbol-level model of the descrambling rules.
module tb_pcie_rx_descrambler;

    localparam int LOCK_TIMEOUT = 16;
    localparam int MAX_SKP      = 5;

    logic ClkPci;
    logic notResetPci;
    int   n_vec;
    int   n_bad;
    bit   dis_q;

    // Reference model state
    logic [15:0] m_lfsr;
    bit          m_locked;
    int          m_idle;
    int          m_skp;
    bit          exp_valid;
    logic [7:0]  exp_data;
    bit          exp_k;
    bit          exp_locked;
    bit          exp_skperr;

    pcie_rx_descrambler_if rx_if ();

    pcie_rx_descrambler #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_SKP      (MAX_SKP)
    ) dut (
        .ClkPci      (ClkPci),
        .notResetPci (notResetPci),
        .bus         (rx_if)
    );

    initial ClkPci = 1'b0;
    always #5 ClkPci = ~ClkPci;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // Scrambler LFSR as sixteen separate bits, one shift per bit time
    function automatic logic [15:0] m_adv8(input logic [15:0] s);
        bit b [16];
        bit o [16];
        logic [15:0] r;
        for (int i = 0; i < 16; i++) b[i] = s[i];
        for (int n = 0; n < 8; n++) begin
            o[0] = b[15];
            o[1] = b[0];
            o[2] = b[1];
            o[3] = b[2] ^ b[15];
            o[4] = b[3] ^ b[15];
            o[5] = b[4] ^ b[15];
            for (int j = 6; j < 16; j++) o[j] = b[j - 1];
            b = o;
        end
        for (int i = 0; i < 16; i++) r[i] = b[i];
        return r;
    endfunction

    function automatic logic [7:0] m_xbyte(input logic [15:0] s);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = s[15 - i];
        return r;
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hFFFF; m_locked = 1'b0; m_idle = 0; m_skp = 0;
        exp_valid = 1'b0; exp_data = 8'h00; exp_k = 1'b0; exp_locked = 1'b0; exp_skperr = 1'b0;
    endtask

    task automatic model_sym(input bit v, input logic [7:0] d, input bit k, input bit dis);
        exp_skperr = 1'b0;
        exp_valid  = v;
        if (!v) begin
            if (m_idle < LOCK_TIMEOUT) m_idle++;
            if (m_locked && m_idle == LOCK_TIMEOUT) m_locked = 1'b0;
        end else begin
            m_idle = 0;
            exp_k  = k;
            if (k && d == 8'hBC) begin
                exp_data = d; m_lfsr = 16'hFFFF; m_skp = 0; m_locked = 1'b1;
            end else if (k && d == 8'h1C) begin
                exp_data = d;
                if (m_skp == MAX_SKP) exp_skperr = 1'b1;
                if (m_skp <= MAX_SKP) m_skp++;
            end else begin
                exp_data = (!k && m_locked && !dis) ? (d ^ m_xbyte(m_lfsr)) : d;
                m_lfsr   = m_adv8(m_lfsr);
                m_skp    = 0;
            end
        end
        exp_locked = m_locked;
    endtask

    // Present one cycle of input; returns #1 after the edge that registers it
    task automatic apply(input bit v, input logic [7:0] d, input bit k);
        @(negedge ClkPci);
        rx_if.RxValid = v; rx_if.RxData = d; rx_if.RxDataK = k; rx_if.DisableScramble = dis_q;
        model_sym(v, d, k, dis_q);
        @(posedge ClkPci);
        #1;
    endtask

    task automatic test_reset();
        notResetPci = 1'b0;
        rx_if.RxValid = 1'b0; rx_if.RxData = 8'h00; rx_if.RxDataK = 1'b0; rx_if.DisableScramble = 1'b0;
        repeat (3) @(posedge ClkPci);
        #1;
        n_vec++;
        if ({rx_if.DescValid, rx_if.DescData, rx_if.DescDataK, rx_if.Locked, rx_if.SkpErr} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_outputs got v=%b d=%h k=%b lk=%b se=%b want all 0",
                     rx_if.DescValid, rx_if.DescData, rx_if.DescDataK, rx_if.Locked, rx_if.SkpErr);
        end
        notResetPci = 1'b1;
        model_reset();
        apply(1'b1, 8'h5A, 1'b0);
        n_vec++;
        if (rx_if.DescData !== 8'h5A || rx_if.Locked !== 1'b0 || rx_if.DescValid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_unlocked_raw got d=%h lk=%b v=%b want 5a/0/1",
                     rx_if.DescData, rx_if.Locked, rx_if.DescValid);
        end
    endtask

    task automatic test_scramble_seq();
        logic [7:0] want [4] = '{8'hFF, 8'h17, 8'hC0, 8'h14};
        apply(1'b1, 8'hBC, 1'b1);
        n_vec++;
        if (rx_if.DescData !== 8'hBC || rx_if.DescDataK !== 1'b1 || rx_if.Locked !== 1'b1) begin
            n_bad++;
            $display("FAIL seq_com got d=%h k=%b lk=%b want bc/1/1", rx_if.DescData, rx_if.DescDataK, rx_if.Locked);
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 8'h00, 1'b0);
            n_vec++;
            if (rx_if.DescData !== want[i] || rx_if.DescDataK !== 1'b0 || rx_if.Locked !== 1'b1) begin
                n_bad++;
                $display("FAIL seq_data[%0d] got d=%h k=%b lk=%b want %h/0/1",
                         i, rx_if.DescData, rx_if.DescDataK, rx_if.Locked, want[i]);
            end
        end
    endtask

    task automatic test_skp_hold();
        logic [7:0] d_in  [5] = '{8'hBC, 8'h00, 8'h1C, 8'h1C, 8'h00};
        bit         k_in  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] want  [5] = '{8'hBC, 8'hFF, 8'h1C, 8'h1C, 8'h17};
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, d_in[i], k_in[i]);
            n_vec++;
            if (rx_if.DescData !== want[i] || rx_if.DescDataK !== k_in[i] || rx_if.DescValid !== 1'b1) begin
                n_bad++;
                $display("FAIL skp_hold[%0d] got d=%h k=%b v=%b want %h/%b/1",
                         i, rx_if.DescData, rx_if.DescDataK, rx_if.DescValid, want[i], k_in[i]);
            end
        end
    endtask

    task automatic test_skp_err();
        apply(1'b1, 8'hBC, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            apply(1'b1, 8'h1C, 1'b1);
            n_vec++;
            if (rx_if.SkpErr !== (i == 6) || rx_if.DescData !== 8'h1C || rx_if.DescDataK !== 1'b1) begin
                n_bad++;
                $display("FAIL skp_err[%0d] got se=%b d=%h k=%b want %b/1c/1",
                         i, rx_if.SkpErr, rx_if.DescData, rx_if.DescDataK, (i == 6));
            end
        end
        apply(1'b1, 8'hBC, 1'b1);
        for (int i = 1; i <= 6; i++) apply(1'b1, 8'h1C, 1'b1);
        n_vec++;
        if (rx_if.SkpErr !== 1'b1) begin
            n_bad++;
            $display("FAIL skp_err_rearm got se=%b want 1", rx_if.SkpErr);
        end
    endtask

    task automatic test_lock_timeout();
        apply(1'b1, 8'hBC, 1'b1);
        for (int i = 1; i <= LOCK_TIMEOUT; i++) begin
            apply(1'b0, 8'h00, 1'b0);
            n_vec++;
            if (rx_if.Locked !== (i < LOCK_TIMEOUT) || rx_if.DescValid !== 1'b0) begin
                n_bad++;
                $display("FAIL lock_timeout[%0d] got lk=%b v=%b want %b/0",
                         i, rx_if.Locked, rx_if.DescValid, (i < LOCK_TIMEOUT));
            end
        end
        apply(1'b1, 8'h5A, 1'b0);
        n_vec++;
        if (rx_if.DescData !== 8'h5A || rx_if.Locked !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_timeout_raw got d=%h lk=%b want 5a/0", rx_if.DescData, rx_if.Locked);
        end
    endtask

    task automatic test_disable();
        logic [7:0] want [3] = '{8'h00, 8'h00, 8'hC0};
        dis_q = 1'b1;
        apply(1'b1, 8'hBC, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) dis_q = 1'b0;
            apply(1'b1, 8'h00, 1'b0);
            n_vec++;
            if (rx_if.DescData !== want[i]) begin
                n_bad++;
                $display("FAIL disable[%0d] got d=%h want %h", i, rx_if.DescData, want[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        apply(1'b1, 8'hBC, 1'b1);
        apply(1'b1, 8'h00, 1'b0);
        apply(1'b1, 8'h00, 1'b0);
        #2;
        notResetPci = 1'b0;
        #1;
        n_vec++;
        if ({rx_if.DescValid, rx_if.DescData, rx_if.DescDataK, rx_if.Locked, rx_if.SkpErr} !== 12'h000) begin
            n_bad++;
            $display("FAIL midreset_async got v=%b d=%h k=%b lk=%b want all 0",
                     rx_if.DescValid, rx_if.DescData, rx_if.DescDataK, rx_if.Locked);
        end
        rx_if.RxValid = 1'b1; rx_if.RxData = 8'hBC; rx_if.RxDataK = 1'b1;
        repeat (2) @(posedge ClkPci);
        #1;
        notResetPci = 1'b1;
        model_reset();
        apply(1'b1, 8'h00, 1'b0);
        n_vec++;
        if (rx_if.DescData !== 8'h00 || rx_if.Locked !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_raw got d=%h lk=%b want 00/0", rx_if.DescData, rx_if.Locked);
        end
        apply(1'b1, 8'hBC, 1'b1);
        apply(1'b1, 8'h00, 1'b0);
        n_vec++;
        if (rx_if.DescData !== 8'hFF || rx_if.Locked !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_relock got d=%h lk=%b want ff/1", rx_if.DescData, rx_if.Locked);
        end
    endtask

    task automatic test_random();
        bit         v;
        bit         k;
        logic [7:0] d;
        int         r;
        int         idle_left;
        idle_left = 0;
        for (int i = 0; i < 600; i++) begin
            if (idle_left == 0 && $urandom_range(0, 39) == 0) idle_left = $urandom_range(14, 18);
            if ($urandom_range(0, 29) == 0) dis_q = ~dis_q;
            if (idle_left > 0) begin
                idle_left--;
                v = 1'b0;
            end else begin
                v = ($urandom_range(0, 9) != 0);
            end
            r = $urandom_range(0, 99);
            if (r < 8)       begin k = 1'b1; d = 8'hBC; end
            else if (r < 38) begin k = 1'b1; d = 8'h1C; end
            else if (r < 43) begin k = 1'b1; d = 8'hF7; end
            else             begin k = 1'b0; d = 8'($urandom); end
            apply(v, d, k);
            n_vec++;
            if (rx_if.DescValid !== exp_valid || rx_if.Locked !== exp_locked || rx_if.SkpErr !== exp_skperr) begin
                n_bad++;
                $display("FAIL random_ctl[%0d] got v=%b lk=%b se=%b want %b/%b/%b", i,
                         rx_if.DescValid, rx_if.Locked, rx_if.SkpErr, exp_valid, exp_locked, exp_skperr);
            end
            if (exp_valid) begin
                n_vec++;
                if (rx_if.DescData !== exp_data || rx_if.DescDataK !== exp_k) begin
                    n_bad++;
                    $display("FAIL random_data[%0d] got d=%h k=%b want %h/%b", i,
                             rx_if.DescData, rx_if.DescDataK, exp_data, exp_k);
                end
            end
        end
        dis_q = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        dis_q = 1'b0;
        model_reset();
        test_reset();
        test_scramble_seq();
        test_skp_hold();
        test_skp_err();
        test_lock_timeout();
        test_disable();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
